// File: rtl/pci_simple_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pci_simple_target                                                        |
// | Simplified 32-bit PCI memory target with single/burst read and write     |
// | to an internal word array. Optional parity: define PCI_TGT_PAR_EN.       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pci_simple_target #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        FRAME_,
    input  logic        IRDY_,
    input  logic [3:0]  C_BE_,
    input  logic [31:0] AD_in,
`ifdef PCI_TGT_PAR_EN
    input  logic        PAR_in,
    output logic        PAR_out,
    output logic        par_oe,
    output logic        perr,
`endif
    output logic [31:0] AD_out,
    output logic        AD_oe,
    output logic        DEVSEL_,
    output logic        TRDY_,
    output logic        ctl_oe,
    output logic        busy,
    output logic        proto_err
);

    localparam int         c_AW     = $clog2(DEPTH);
    localparam int         c_W      = c_AW + 2;
    localparam logic [3:0] c_CMD_RD = 4'b0110;
    localparam logic [3:0] c_CMD_WR = 4'b0111;
    localparam logic [2:0] c_WS     = 3'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DATA = 2'd2,
        S_TURN = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_frame_prev;
    logic              r_claim;
    logic              r_is_read;
    logic              r_devsel_n;
    logic              r_trdy_n;
    logic              r_ad_oe;
    logic              r_ctl_oe;
    logic              r_proto_err;
    logic [c_AW-1:0]   r_ptr;
    logic [2:0]        r_wcnt;
    logic [31:0]       r_mem [DEPTH];

    logic w_addr_phase;
    logic w_hit;
    logic w_cmd_ok;
    logic w_xfer;
    logic w_viol;

    assign w_addr_phase = r_frame_prev & ~FRAME_;
    assign w_hit        = (AD_in[31:c_W] == BASE_ADDR[31:c_W]);
    assign w_cmd_ok     = (C_BE_ == c_CMD_RD) || (C_BE_ == c_CMD_WR);
    assign w_xfer       = (r_state == S_DATA) & ~IRDY_ & ~r_trdy_n;
    assign w_viol       = ((r_state == S_WAIT) || (r_state == S_DATA)) & FRAME_ & IRDY_;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_frame_prev <= 1'b1;
            r_claim      <= 1'b0;
            r_is_read    <= 1'b0;
            r_devsel_n   <= 1'b1;
            r_trdy_n     <= 1'b1;
            r_ad_oe      <= 1'b0;
            r_ctl_oe     <= 1'b0;
            r_proto_err  <= 1'b0;
            r_ptr        <= '0;
            r_wcnt       <= 3'd0;
        end else begin
            r_frame_prev <= FRAME_;
            r_proto_err  <= 1'b0;
            r_claim      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Decode is registered: the claim takes effect one edge after the address phase.
                    if (r_claim) begin
                        r_devsel_n <= 1'b0;
                        r_ctl_oe   <= 1'b1;
                        r_wcnt     <= c_WS;
                        if (c_WS == 3'd0) begin
                            r_trdy_n <= 1'b0;
                            r_state  <= S_DATA;
                        end else begin
                            r_state  <= S_WAIT;
                        end
                    end else if (w_addr_phase && w_hit && w_cmd_ok) begin
                        r_claim   <= 1'b1;
                        r_ptr     <= AD_in[c_W-1:2];
                        r_is_read <= (C_BE_ == c_CMD_RD);
                    end
                end
                S_WAIT: begin
                    if (w_viol) begin
                        r_proto_err <= 1'b1;
                        r_state     <= S_TURN;
                        r_devsel_n  <= 1'b1;
                        r_trdy_n    <= 1'b1;
                        r_ad_oe     <= 1'b0;
                    end else begin
                        r_ad_oe <= r_is_read;
                        if (r_wcnt <= 3'd1) begin
                            r_trdy_n <= 1'b0;
                            r_state  <= S_DATA;
                        end else begin
                            r_wcnt <= r_wcnt - 3'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_viol) begin
                        r_proto_err <= 1'b1;
                        r_state     <= S_TURN;
                        r_devsel_n  <= 1'b1;
                        r_trdy_n    <= 1'b1;
                        r_ad_oe     <= 1'b0;
                    end else begin
                        r_ad_oe <= r_is_read;
                        if (w_xfer) begin
                            r_ptr <= r_ptr + c_AW'(1);
                            if (FRAME_) begin
                                r_state    <= S_TURN;
                                r_devsel_n <= 1'b1;
                                r_trdy_n   <= 1'b1;
                                r_ad_oe    <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_ctl_oe <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    // Memory is not reset; a transfer coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && w_xfer && !r_is_read) begin
            for (int i = 0; i < 4; i++) begin
                if (!C_BE_[i]) begin
                    r_mem[r_ptr][8*i +: 8] <= AD_in[8*i +: 8];
                end
            end
        end
    end

    assign AD_out    = (r_is_read && !r_trdy_n) ? r_mem[r_ptr] : 32'h0;
    assign AD_oe     = r_ad_oe;
    assign DEVSEL_   = r_devsel_n;
    assign TRDY_     = r_trdy_n;
    assign ctl_oe    = r_ctl_oe;
    assign busy      = (r_state != S_IDLE);
    assign proto_err = r_proto_err;

`ifdef PCI_TGT_PAR_EN
    logic r_par;
    logic r_par_oe;
    logic r_wpar_exp;
    logic r_wchk;
    logic r_perr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par      <= 1'b0;
            r_par_oe   <= 1'b0;
            r_wpar_exp <= 1'b0;
            r_wchk     <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_par_oe <= w_xfer & r_is_read;
            r_wchk   <= w_xfer & ~r_is_read;
            r_perr   <= r_wchk & (PAR_in != r_wpar_exp);
            if (w_xfer && r_is_read) begin
                r_par <= ^{AD_out, C_BE_};
            end
            if (w_xfer && !r_is_read) begin
                r_wpar_exp <= ^{AD_in, C_BE_};
            end
        end
    end

    assign PAR_out = r_par;
    assign par_oe  = r_par_oe;
    assign perr    = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pci_simple_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pci_simple_target                                                     |
// | Self-checking bench: vector table, directed sequences, random bursts.    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pci_simple_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        FRAME_;
    logic        IRDY_;
    logic [3:0]  C_BE_;
    logic [31:0] AD_in;
    logic [31:0] AD_out;
    logic        AD_oe;
    logic        DEVSEL_;
    logic        TRDY_;
    logic        ctl_oe;
    logic        busy;
    logic        proto_err;

    pci_simple_target dut (
        .clk       (clk),
        .reset     (reset),
        .FRAME_    (FRAME_),
        .IRDY_     (IRDY_),
        .C_BE_     (C_BE_),
        .AD_in     (AD_in),
        .AD_out    (AD_out),
        .AD_oe     (AD_oe),
        .DEVSEL_   (DEVSEL_),
        .TRDY_     (TRDY_),
        .ctl_oe    (ctl_oe),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] g_wd [16];
    logic [3:0]  g_be [16];
    logic [31:0] last_rd;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  cmd;
        logic        exp_dev;
        logic        exp_ctl;
        logic        exp_busy;
    } vec_t;
    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Master-side transaction driver; the reference model applies each transfer.
    task automatic xact(input bit rd, input logic [31:0] addr, input int n,
                        input int wait_phase, input int waits, input bit chk_tm);
        int ptr, k, cnt, w, t_dev, t_trdy, t_oe;
        ptr = int'(addr[5:2]); k = 0; cnt = 0; w = waits;
        t_dev = -1; t_trdy = -1; t_oe = -1;
        FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = addr;
        C_BE_  = rd ? 4'b0110 : 4'b0111;
        cyc();
        while (k < n && cnt < 60) begin
            AD_in  = rd ? $urandom() : g_wd[k];
            C_BE_  = rd ? 4'($urandom_range(0, 15)) : g_be[k];
            IRDY_  = (k == wait_phase && w > 0) ? 1'b1 : 1'b0;
            FRAME_ = (k == n - 1 && !IRDY_) ? 1'b1 : 1'b0;
            if (!TRDY_ && IRDY_) begin
                if (rd) chk("hold_data", AD_out, ref_mem[ptr]);
                w--;
            end else if (!TRDY_) begin
                if (rd) begin
                    chk("rd_data", AD_out, ref_mem[ptr]);
                    last_rd = AD_out;
                end else begin
                    for (int b = 0; b < 4; b++)
                        if (!g_be[k][b]) ref_mem[ptr][8*b +: 8] = g_wd[k][8*b +: 8];
                end
                ptr = (ptr + 1) % 16;
                k++;
            end
            cyc();
            cnt++;
            if (t_dev < 0 && !DEVSEL_) t_dev = cnt;
            if (t_trdy < 0 && !TRDY_) t_trdy = cnt;
            if (t_oe < 0 && AD_oe) t_oe = cnt;
        end
        chk("xact_done", 32'(k), 32'(n));
        IRDY_ = 1'b1; FRAME_ = 1'b1;
        chk("turn_state", {27'd0, DEVSEL_, TRDY_, AD_oe, ctl_oe, busy}, 32'b11011);
        cyc();
        chk("idle_state", {26'd0, DEVSEL_, TRDY_, AD_oe, ctl_oe, busy, proto_err}, 32'b110000);
        if (chk_tm) begin
            chk("t_devsel", 32'(t_dev), 32'd1);
            chk("t_trdy", 32'(t_trdy), 32'd2);
            chk("t_ad_oe", 32'(t_oe), rd ? 32'd2 : 32'hFFFF_FFFF);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        tbl[0] = '{32'h2000_0000, 4'b0111, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{32'h1000_0000, 4'b0010, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{32'h1000_0040, 4'b0110, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{32'h0FFF_FFFC, 4'b0111, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{32'h1000_003C, 4'b0110, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{32'h1000_0000, 4'b0111, 1'b0, 1'b1, 1'b1};
        tbl[6] = '{32'h1000_0004, 4'b0000, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h1000_0004, 4'b1110, 1'b1, 1'b0, 1'b0};

        reset = 1'b1; FRAME_ = 1'b1; IRDY_ = 1'b1; C_BE_ = 4'hF; AD_in = 32'h0;
        cyc(); cyc();
        chk("rst_devsel", {31'd0, DEVSEL_}, 32'd1);
        chk("rst_trdy", {31'd0, TRDY_}, 32'd1);
        chk("rst_ad_oe", {31'd0, AD_oe}, 32'd0);
        chk("rst_ctl_oe", {31'd0, ctl_oe}, 32'd0);
        chk("rst_ad_out", AD_out, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
        reset = 1'b0;
        cyc();

        // Preload every word so later reads have defined expectations.
        for (int i = 0; i < 16; i++) begin g_wd[i] = $urandom(); g_be[i] = 4'h0; end
        xact(1'b0, 32'h1000_0000, 16, 0, 0, 1'b1);

        // Decode table: claim or ignore for each address/command pair.
        for (int i = 0; i < 8; i++) begin
            FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = tbl[i].addr; C_BE_ = tbl[i].cmd;
            cyc();
            FRAME_ = 1'b1; IRDY_ = 1'b0; AD_in = $urandom(); C_BE_ = 4'hF;
            cyc();
            chk("tbl_devsel", {31'd0, DEVSEL_}, {31'd0, tbl[i].exp_dev});
            chk("tbl_ctl_oe", {31'd0, ctl_oe}, {31'd0, tbl[i].exp_ctl});
            chk("tbl_busy", {31'd0, busy}, {31'd0, tbl[i].exp_busy});
            cnt = 0;
            while ((busy || !DEVSEL_ || ctl_oe) && cnt < 10) begin cyc(); cnt++; end
            chk("tbl_drain", 32'(cnt < 10), 32'd1);
            IRDY_ = 1'b1;
            cyc();
        end

        g_wd[0] = 32'hDEAD_BEEF; g_be[0] = 4'h0;
        xact(1'b0, 32'h1000_0008, 1, 0, 0, 1'b1);
        xact(1'b1, 32'h1000_0008, 1, 0, 0, 1'b1);
        chk("single_rd", last_rd, 32'hDEAD_BEEF);

        g_wd[0] = 32'h1122_3344; g_be[0] = 4'h0;
        xact(1'b0, 32'h1000_000C, 1, 0, 0, 1'b0);
        g_wd[0] = 32'hAABB_CCDD; g_be[0] = 4'b1010;
        xact(1'b0, 32'h1000_000C, 1, 0, 0, 1'b0);
        xact(1'b1, 32'h1000_000C, 1, 0, 0, 1'b0);
        chk("byte_en", last_rd, 32'h11BB_33DD);

        for (int i = 0; i < 4; i++) begin g_wd[i] = 32'(i + 1); g_be[i] = 4'h0; end
        xact(1'b0, 32'h1000_0038, 4, 0, 0, 1'b0);
        xact(1'b1, 32'h1000_0038, 4, 0, 0, 1'b1);
        chk("wrap_last", last_rd, 32'd4);

        xact(1'b1, 32'h1000_0038, 4, 1, 3, 1'b0);

        // Master drops FRAME_ while IRDY_ is still deasserted.
        FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = 32'h1000_0014; C_BE_ = 4'b0111;
        cyc();
        AD_in = 32'h5555_AAAA; C_BE_ = 4'h0; cnt = 0;
        while (TRDY_ && cnt < 10) begin cyc(); cnt++; end
        chk("viol_reach_data", {30'd0, DEVSEL_, TRDY_}, 32'd0);
        FRAME_ = 1'b1;
        cyc();
        chk("viol_pulse", {31'd0, proto_err}, 32'd1);
        chk("viol_turn", {28'd0, DEVSEL_, TRDY_, ctl_oe, busy}, 32'b1111);
        cyc();
        chk("viol_idle", {29'd0, proto_err, ctl_oe, busy}, 32'd0);
        xact(1'b1, 32'h1000_0014, 1, 0, 0, 1'b0);

        // Reset while the claim is in WAIT.
        FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = 32'h1000_0010; C_BE_ = 4'b0110;
        cyc();
        FRAME_ = 1'b1; IRDY_ = 1'b0;
        cyc();
        chk("wait_claimed", {30'd0, DEVSEL_, busy}, 32'b01);
        #2 reset = 1'b1; #1;
        chk("rst_in_wait", {26'd0, DEVSEL_, TRDY_, AD_oe, ctl_oe, busy, proto_err}, 32'b110000);
        IRDY_ = 1'b1;
        cyc(); reset = 1'b0; cyc();

        // Reset just before a write transfer edge: the write must be lost.
        FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = 32'h1000_0018; C_BE_ = 4'b0111;
        cyc();
        AD_in = 32'hCAFE_F00D; C_BE_ = 4'h0; cnt = 0;
        while (TRDY_ && cnt < 10) begin cyc(); cnt++; end
        chk("disc_in_data", {30'd0, DEVSEL_, TRDY_}, 32'd0);
        IRDY_ = 1'b0; FRAME_ = 1'b1;
        #2 reset = 1'b1; #1;
        chk("rst_in_data", {26'd0, DEVSEL_, TRDY_, AD_oe, ctl_oe, busy, proto_err}, 32'b110000);
        cyc(); reset = 1'b0; IRDY_ = 1'b1; cyc();
        xact(1'b1, 32'h1000_0018, 1, 0, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                g_wd[i] = $urandom();
                g_be[i] = 4'($urandom_range(0, 15));
            end
            xact(1'($urandom_range(0, 1)), 32'h1000_0000 + 32'($urandom_range(0, 15) * 4),
                 n, $urandom_range(0, n - 1), $urandom_range(0, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pci_simple_target.md
Name: pci_simple_target

Overview:
- Simplified 32-bit PCI memory target: the responder end of the bus that the PCI protocol checkers observe.
- Decodes the address phase and claims accesses that hit its window, asserting DEVSEL_ and TRDY_.
- Completes single and burst memory reads/writes against an internal word array.
- Sits on the PCI bench bus alongside the master model and the protocol property module.

Parameters:
BASE_ADDR, 32'h1000_0000, window base; must be aligned to DEPTH*4 bytes
DEPTH, 16, number of 32-bit words (power of 2, 2..256)
WAIT_STATES, 1, TRDY_ wait cycles before the first data phase (0..7)

Ports:
clk  in  1  bus clock, rising-edge
reset  in  1  asynchronous, active-high reset
FRAME_  in  1  master frame, active-low
IRDY_  in  1  master ready, active-low
C_BE_  in  4  command (address phase) / byte enables (data phase), active-low
AD_in  in  32  AD bus as sampled
AD_out  out  32  read data driven onto AD
AD_oe  out  1  AD drive enable
DEVSEL_  out  1  device select, active-low
TRDY_  out  1  target ready, active-low
ctl_oe  out  1  drive enable for DEVSEL_/TRDY_
busy  out  1  high while not IDLE
proto_err  out  1  one-cycle pulse on master protocol violation

Behaviour:
- Reset: DEVSEL_=1, TRDY_=1, AD_oe=0, ctl_oe=0, AD_out=0, busy=0, proto_err=0, state IDLE. Memory contents are not reset.
- Commands: 4'b0110 is MemRead, 4'b0111 is MemWrite; all others are ignored.
- Hit: AD_in[31:W]==BASE_ADDR[31:W], with W=log2(DEPTH)+2.
- IDLE:
  - Address phase = clock edge where FRAME_ is sampled 0 after being sampled 1 on the previous edge.
  - Hit plus valid command: latch word pointer AD_in[W-1:2] and the command; go to WAIT.
  - Otherwise stay IDLE. No DEVSEL_, i.e. master abort is the master's problem.
- WAIT:
  - Entered edge N+1 after the address phase (fast decode). DEVSEL_=0, ctl_oe=1.
  - Reads: AD_oe=1 from edge N+2 (one turnaround cycle).
  - Hold TRDY_=1 for WAIT_STATES cycles, then TRDY_=0 and go to DATA.
  - WAIT_STATES=0: TRDY_=0 together with DEVSEL_ at edge N+1.
- DATA:
  - Transfer occurs on every edge with IRDY_=0 and TRDY_=0.
  - Write: for each byte lane i with C_BE_[i]=0, mem[ptr][8i+7:8i] <= AD_in byte i.
  - Read: AD_out equals mem[ptr] while TRDY_=0.
  - After each transfer ptr increments, wrapping DEPTH-1 -> 0 within the window.
  - TRDY_ stays 0 through the burst (zero wait after the first data phase).
  - IRDY_=1 with TRDY_=0: no transfer; hold the pointer and data.
- Completion: on a transfer edge where FRAME_=1, the transfer is the last one; go to TURN.
- TURN (1 cycle): DEVSEL_=1, TRDY_=1, AD_oe=0, ctl_oe=1 (drive high). Then IDLE with ctl_oe=0.
- Violation:
  - In WAIT or DATA, FRAME_=1 sampled with IRDY_=1 (FRAME_ deasserted without IRDY_ asserted).
  - Response: pulse proto_err for one cycle and go to TURN; no transfer.
- Reads are never combinationally dependent on AD_in. Write data is committed on the transfer edge.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously); the pending transfer is discarded.
- busy=1 in WAIT, DATA and TURN.

Optional Feature:
PCI_TGT_PAR_EN
- Enabled adds ports PAR_in (in, 1), PAR_out (out, 1), par_oe (out, 1), perr (out, 1).
- Read data phase: the cycle after each read transfer, PAR_out = ^{AD_out, C_BE_} (even parity) and par_oe=1.
- Write: the cycle after each write transfer, compare PAR_in against ^{AD_in, C_BE_} from the transfer edge; on mismatch pulse perr for one cycle. Write data is still committed.
- Disabled: ports absent, no parity logic.

Test Plan:
- Single write then read: write addr 32'h1000_0008, C_BE_=0000, data 32'hDEAD_BEEF; read the same address -> DEVSEL_ low edge N+1, TRDY_ low edge N+2 (WAIT_STATES=1), AD_out=32'hDEAD_BEEF, TURN then IDLE.
- Byte enables: mem[3]=32'h1122_3344, write 32'hAABB_CCDD to word 3 with C_BE_=4'b1010 -> mem[3]=32'h11BB_33DD.
- Burst wrap: 4-word write at 32'h1000_0038 (word 14), data 1,2,3,4 -> mem[14]=1, mem[15]=2, mem[0]=3, mem[1]=4; a burst read returns the same values in the same order.
- Master wait: IRDY_ held high for 3 cycles during a read burst -> TRDY_ stays 0, AD_out stable, ptr unchanged; transfer completes when IRDY_ falls.
- Miss/ignore: address 32'h2000_0000 or C_BE_=4'b0010 -> DEVSEL_ stays 1, ctl_oe=0, busy=0.
- Violation and reset: FRAME_ rises with IRDY_=1 in DATA -> proto_err one pulse, TURN, IDLE. Asserting reset during WAIT -> outputs return to reset values immediately.
